// File: rtl/pc_call_stack.sv
// rtl/pc_call_stack.sv - program counter with hardware return-address stack
// Optional skip operation (pc+2) is built only when PC_SKIP_EN is defined.
module pc_call_stack #(
  parameter int N     = 12,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_en,
  input  logic [N-1:0]                 load_addr,
  input  logic                         call_en,
  input  logic [N-1:0]                 call_addr,
  input  logic                         ret_en,
  input  logic                         inc_en,
`ifdef PC_SKIP_EN
  input  logic                         skip_en,
`endif
  input  logic                         err_clr,
  output logic [N-1:0]                 pc,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         stk_full,
  output logic                         stk_empty,
  output logic                         ovf,
  output logic                         unf
);
  localparam int D = $clog2(DEPTH+1);

  logic [N-1:0] stack [DEPTH];
  logic [N-1:0] top;
  logic [N-1:0] pc_plus1;
  logic [N-1:0] pc_next;
  logic [D-1:0] sp_next;
  logic         push;
  logic         ovf_set;
  logic         unf_set;

  assign pc_plus1  = pc + N'(1);
  assign stk_full  = (sp == D'(DEPTH));
  assign stk_empty = (sp == '0);

  // Top-of-stack is the entry just below sp; slot sp itself is never read.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp == D'(i + 1)) top = stack[i];
    end
  end

  always_comb begin
    pc_next = pc;
    sp_next = sp;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (load_en) begin
      pc_next = load_addr;
    end else if (ret_en) begin
      if (stk_empty) begin
        pc_next = pc_plus1;
        unf_set = 1'b1;
      end else begin
        pc_next = top;
        sp_next = sp - D'(1);
      end
    end else if (call_en) begin
      if (stk_full) begin
        pc_next = pc_plus1;
        ovf_set = 1'b1;
      end else begin
        pc_next = call_addr;
        sp_next = sp + D'(1);
        push    = 1'b1;
      end
`ifdef PC_SKIP_EN
    end else if (skip_en) begin
      pc_next = pc + N'(2);
`endif
    end else if (inc_en) begin
      pc_next = pc_plus1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= '0;
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      pc  <= pc_next;
      sp  <= sp_next;
      // Set wins over a simultaneous clear.
      ovf <= ovf_set | (ovf & ~err_clr);
      unf <= unf_set | (unf & ~err_clr);
      for (int i = 0; i < DEPTH; i++) begin
        if (push && sp == D'(i)) stack[i] <= pc_plus1;
      end
    end
  end
endmodule
